// File: rtl/exception_ctrl.sv
// Exception/eret sequencer: forwards CP0 state, writes EPC/Cause/Status one per cycle, then flushes.
// Latency: flush 4 cycles after accept (exception), 2 cycles (eret). Optional macro: EXC_INT_EN enables interrupts.
module exception_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [4:0]  exc_req_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STATUS = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  localparam logic [4:0]  REG_STATUS = 5'd12;
  localparam logic [4:0]  REG_CAUSE  = 5'd13;
  localparam logic [4:0]  REG_EPC    = 5'd14;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  state_t      state_q, state_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic        eret_q, eret_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] status_q, status_d;

  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_pending;
  logic        take_exc, take_eret;
  logic [4:0]  exccode_sel;

  // Forward an in-flight CP0 write; only the software-writable Cause bits come from it.
  always_comb begin
    eff_status = status_i;
    eff_epc    = epc_i;
    eff_cause  = cause_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == REG_STATUS) eff_status = wb_cp0_data_i;
      if (wb_cp0_waddr_i == REG_EPC)    eff_epc    = wb_cp0_data_i;
      if (wb_cp0_waddr_i == REG_CAUSE) begin
        eff_cause[9:8]   = wb_cp0_data_i[9:8];
        eff_cause[23:22] = wb_cp0_data_i[23:22];
      end
    end
  end

`ifdef EXC_INT_EN
  assign int_pending = ((eff_cause[15:8] & eff_status[15:8]) != 8'd0) &&
                       eff_status[0] && !eff_status[1];
`else
  assign int_pending = 1'b0;
`endif

  always_comb begin
    take_exc    = 1'b1;
    take_eret   = 1'b0;
    exccode_sel = 5'd0;
    if (int_pending)       exccode_sel = 5'd0;
    else if (exc_req_i[0]) exccode_sel = 5'd8;
    else if (exc_req_i[1]) exccode_sel = 5'd10;
    else if (exc_req_i[2]) exccode_sel = 5'd13;
    else if (exc_req_i[3]) exccode_sel = 5'd12;
    else begin
      take_exc  = 1'b0;
      take_eret = exc_req_i[4];
    end
  end

  always_comb begin
    state_d     = state_q;
    exccode_d   = exccode_q;
    bd_d        = bd_q;
    eret_d      = eret_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    status_d    = status_q;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_data_o  = 32'd0;
    stall_o     = 1'b1;
    flush_o     = 1'b0;
    new_pc_o    = 32'd0;
    unique case (state_q)
      IDLE: begin
        stall_o = 1'b0;
        if (valid_i && take_exc) begin
          exccode_d = exccode_sel;
          bd_d      = in_delayslot_i;
          eret_d    = 1'b0;
          epc_d     = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause_d   = eff_cause;
          status_d  = eff_status;
          state_d   = W_EPC;
        end else if (valid_i && take_eret) begin
          eret_d   = 1'b1;
          epc_d    = eff_epc;
          status_d = eff_status;
          state_d  = W_STATUS;
        end
      end
      W_EPC: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = REG_EPC;
        cp0_data_o  = epc_q;
        state_d     = W_CAUSE;
      end
      W_CAUSE: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = REG_CAUSE;
        cp0_data_o  = {bd_q, cause_q[30:7], exccode_q, cause_q[1:0]};
        state_d     = W_STATUS;
      end
      W_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = REG_STATUS;
        cp0_data_o  = {status_q[31:2], ~eret_q, status_q[0]};
        state_d     = FLUSH;
      end
      FLUSH: begin
        flush_o  = 1'b1;
        new_pc_o = eret_q ? epc_q : EXC_VECTOR;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      exccode_q <= 5'd0;
      bd_q      <= 1'b0;
      eret_q    <= 1'b0;
      epc_q     <= 32'd0;
      cause_q   <= 32'd0;
      status_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      exccode_q <= exccode_d;
      bd_q      <= bd_d;
      eret_q    <= eret_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      status_q  <= status_d;
    end
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: valid_i  in  1  mem-stage instruction valid; pc_i  in  32  its PC; in_delayslot_i  in  1  instruction sits in a branch delay slot.
REQ-004 SHALL have ports: exc_req_i  in  5  one-hot-or-zero request flags, bit0 syscall, bit1 reserved-instruction, bit2 trap, bit3 overflow, bit4 eret.
REQ-005 SHALL have ports: status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC values.
REQ-006 SHALL have ports: wb_cp0_we_i  in  1, wb_cp0_waddr_i  in  5, wb_cp0_data_i  in  32  in-flight CP0 write (forwarding source).
REQ-007 SHALL have ports: cp0_we_o  out  1, cp0_waddr_o  out  5, cp0_data_o  out  32  single CP0 write port toward the CP0 register file.
REQ-008 SHALL have ports: stall_o  out  1  pipeline hold; flush_o  out  1  one-cycle pipeline flush; new_pc_o  out  32  redirect target, valid only while flush_o=1.

Function
REQ-009 SHALL forward in IDLE: effective Status = wb_cp0_data_i if wb_cp0_we_i and waddr=12, else status_i; EPC likewise for waddr=14; Cause bits [9:8],[23:22] from wb_cp0_data_i if waddr=13, all other Cause bits from cause_i.
REQ-010 SHALL detect interrupt when (Cause[15:8] & Status[15:8]) != 0, Status[0]=1, Status[1]=0 (effective values).
REQ-011 SHALL prioritise, accepting at most one event per valid_i: interrupt (ExcCode 0) > syscall (8) > RI (10) > trap (13) > overflow (12) > eret.
REQ-012 SHALL use states IDLE, W_EPC, W_CAUSE, W_STATUS, FLUSH; stall_o=1 in every state except IDLE.
REQ-013 SHALL, on an edge in IDLE with valid_i=1 and an exception, latch ExcCode, BD=in_delayslot_i, EPC value = pc_i-4 if in_delayslot_i else pc_i, effective Cause and Status; next state W_EPC.
REQ-014 SHALL in W_EPC drive cp0_we_o=1, waddr=14, data=latched EPC value; next W_CAUSE.
REQ-015 SHALL in W_CAUSE drive waddr=13, data=latched Cause with [6:2]=ExcCode, [31]=BD; next W_STATUS.
REQ-016 SHALL in W_STATUS drive waddr=12, data=latched Status with bit1 set (exception) or cleared (eret); next FLUSH.
REQ-017 SHALL, on eret accepted in IDLE, latch effective EPC and Status and go directly to W_STATUS.
REQ-018 SHALL in FLUSH assert flush_o=1 for exactly one cycle, new_pc_o=32'h00000020 (exception) or latched EPC (eret); next IDLE.
REQ-019 SHALL hold cp0_we_o=0, cp0_waddr_o=0, cp0_data_o=0, flush_o=0, new_pc_o=0 outside the states that drive them.
REQ-020 SHALL give latency from accepting edge: flush_o high 4 cycles later for exceptions, 2 cycles later for eret.
REQ-021 SHALL ignore valid_i and exc_req_i in all non-IDLE states; valid_i=0 or no event in IDLE stays IDLE with no outputs.
REQ-022 SHALL apply forwarding on the accepting edge even when the wb write targets the same register in that cycle.

Reset
REQ-023 SHALL, while rst=0, immediately force state IDLE, all outputs 0 and all latched registers 0, including mid-sequence; first acceptance possible on the first edge after rst rises.

Configuration
REQ-024 SHALL, with EXC_INT_EN defined, implement REQ-010 interrupt detection; without it, never take interrupts (Cause/Status IP/IE bits ignored), synchronous exceptions and eret unchanged.

Verification
REQ-025 syscall at pc_i=0x100, Status=0x10000001 -> W_EPC writes 0x100 to reg14, Cause reg13 [6:2]=8, Status reg12=0x10000003, flush_o with new_pc_o=0x20 4 cycles after accept.
REQ-026 overflow at pc_i=0x204, in_delayslot_i=1 -> EPC=0x200, Cause[31]=1, ExcCode=12.
REQ-027 eret with epc_i=0x80, wb write reg14=0x1234 same cycle -> Status EXL cleared, flush_o 2 cycles later, new_pc_o=0x1234.
REQ-028 cause_i[10]=1, Status=0x00000401, syscall simultaneous -> ExcCode 0 with EXC_INT_EN; ExcCode 8 without.
REQ-029 rst=0 pulse during W_CAUSE -> outputs 0 at once, no Status write, no flush; next syscall after release processed normally.
